sort_host: RTL and testbench

SORT_HOST -- requirements
Module: sort_host

---
 rtl/sort_host_pkg.sv | 24 ++
 rtl/sort_host.sv | 131 +++++++++++++
 tb/tb_sort_host.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_host_pkg.sv
// rtl/sort_host_pkg.sv - shared types and constants for the sort host
package sort_host_pkg;

    localparam int unsigned NUM_ROWS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 8;

    typedef logic [ADDR_W-1:0] t_addr;
    typedef logic [DATA_W-1:0] t_data;

    // Gray-coded so every legal transition flips a single bit.
    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_KICK   = 2'b01,
        ST_SORT   = 2'b11,
        ST_UNLOAD = 2'b10
    } state_t;

    // Index of the final row of a frame; the pointer is only ever compared to this.
    function automatic t_addr last_row(input int unsigned rows);
        return t_addr'(rows - 1);
    endfunction

endpackage

// File: rtl/sort_host.sv
// rtl/sort_host.sv - load/kick/sort/unload host around an external array and sort controller
module sort_host
    import sort_host_pkg::*;
#(
    parameter int unsigned FRAME_ROWS = NUM_ROWS
) (
    input  logic  clk,
    input  logic  rst_n,

    input  logic  in_valid,
    output logic  in_ready,
    input  t_data in_data,

    output logic  out_valid,
    input  logic  out_ready,
    output t_data out_data,
    output logic  out_last,

    output logic  sort_start,
    input  logic  sort_done,

    input  t_addr ctl_rd_addr,
    output t_data ctl_rd_data,
    input  logic  ctl_wr_en,
    input  t_addr ctl_wr_addr,
    input  t_data ctl_wr_data,

    output t_addr mem_rd_addr,
    input  t_data mem_rd_data,
    output logic  mem_wr_en,
    output t_addr mem_wr_addr,
    output t_data mem_wr_data,

    output logic  busy
);

    localparam t_addr LAST = last_row(FRAME_ROWS);

    state_t state;
    t_addr  ptr;

    // State decodes are qualified by rst_n so every output is quiet while reset is held,
    // including a ctl write that coincides with the reset edge.
    logic in_load;
    logic in_kick;
    logic in_sort;
    logic in_unload;
    logic at_last;

    assign in_load   = rst_n && (state == ST_LOAD);
    assign in_kick   = rst_n && (state == ST_KICK);
    assign in_sort   = rst_n && (state == ST_SORT);
    assign in_unload = rst_n && (state == ST_UNLOAD);
    assign at_last   = (ptr == LAST);

    // Stream handshakes, array port steering and status flags.
    always_comb begin
        in_ready    = in_load;
        out_valid   = in_unload;
        out_data    = in_unload ? mem_rd_data : '0;
        out_last    = in_unload && at_last;
        sort_start  = in_kick;
        busy        = in_kick || in_sort;
        ctl_rd_data = mem_rd_data;

        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;

        if (in_sort) begin
            mem_rd_addr = ctl_rd_addr;
            mem_wr_en   = ctl_wr_en;
            if (ctl_wr_en) begin
                mem_wr_addr = ctl_wr_addr;
                mem_wr_data = ctl_wr_data;
            end
        end else if (in_unload) begin
            mem_rd_addr = ptr;
        end else if (in_load && in_valid) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = ptr;
            mem_wr_data = in_data;
        end
    end

    // Frame sequencer: pointer advances only on handshakes and is cleared on every phase change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
            ptr   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (at_last) begin
                            state <= ST_KICK;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + t_addr'(1);
                        end
                    end
                end
                ST_KICK: begin
                    state <= ST_SORT;
                end
                ST_SORT: begin
                    if (sort_done) begin
                        state <= ST_UNLOAD;
                        ptr   <= '0;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state <= ST_LOAD;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + t_addr'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_host.sv
// tb/tb_sort_host.sv - randomized self-checking bench for sort_host with array and sorter models
module tb_sort_host;
    import sort_host_pkg::*;

    typedef logic [7:0] frame_t [4];

    logic  clk;
    logic  rst_n;
    logic  in_valid;
    logic  in_ready;
    t_data in_data;
    logic  out_valid;
    logic  out_ready;
    t_data out_data;
    logic  out_last;
    logic  sort_start;
    logic  sort_done;
    t_addr ctl_rd_addr;
    t_data ctl_rd_data;
    logic  ctl_wr_en;
    t_addr ctl_wr_addr;
    t_data ctl_wr_data;
    t_addr mem_rd_addr;
    t_data mem_rd_data;
    logic  mem_wr_en;
    t_addr mem_wr_addr;
    t_data mem_wr_data;
    logic  busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];

    sort_host #(.FRAME_ROWS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .sort_start  (sort_start),
        .sort_done   (sort_done),
        .ctl_rd_addr (ctl_rd_addr),
        .ctl_rd_data (ctl_rd_data),
        .ctl_wr_en   (ctl_wr_en),
        .ctl_wr_addr (ctl_wr_addr),
        .ctl_wr_data (ctl_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic frame_t sort4(input frame_t a);
        frame_t r = a;
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (r[j] < r[j-1]) begin
                    logic [7:0] t = r[j];
                    r[j]   = r[j-1];
                    r[j-1] = t;
                end
            end
        end
        return r;
    endfunction

    // Loads one frame with optional idle gaps; poke drives stray sort_done/ctl writes during gaps.
    task automatic load_frame(input frame_t v, input int max_gap, input bit poke);
        for (int i = 0; i < 4; i++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid    = 1'b0;
                sort_done   = poke;
                ctl_wr_en   = poke;
                ctl_wr_addr = (i == 0) ? t_addr'(0) : t_addr'(i - 1);
                ctl_wr_data = 8'hEE;
                #1;
                chk("load_idle_ready", in_ready, 1);
                chk("load_idle_wr_en", mem_wr_en, 0);
                tick();
            end
            sort_done = 1'b0;
            ctl_wr_en = poke;
            in_valid  = 1'b1;
            in_data   = v[i];
            #1;
            chk("load_ready", in_ready, 1);
            chk("load_wr_en", mem_wr_en, 1);
            chk("load_wr_addr", mem_wr_addr, i);
            chk("load_wr_data", mem_wr_data, v[i]);
            chk("load_busy", busy, 0);
            tick();
        end
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        ctl_wr_en = 1'b1;
        #1;
        chk("kick_start", sort_start, 1);
        chk("kick_busy", busy, 1);
        chk("kick_ready", in_ready, 0);
        chk("kick_wr_en", mem_wr_en, 0);
        tick();
        in_valid  = 1'b0;
        ctl_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) chk("load_mem", mem[i], v[i]);
    endtask

    // Behavioural sort controller: read all rows through the ctl port, write back sorted, pulse done.
    task automatic run_sorter();
        frame_t r;
        frame_t s;
        for (int i = 0; i < 4; i++) begin
            ctl_rd_addr = t_addr'(i);
            ctl_wr_en   = 1'b0;
            in_valid    = 1'b1;
            #1;
            chk("sort_busy", busy, 1);
            chk("sort_start_low", sort_start, 0);
            chk("sort_rd_addr", mem_rd_addr, i);
            chk("sort_rd_data", ctl_rd_data, mem[i]);
            chk("sort_in_ready", in_ready, 0);
            chk("sort_out_valid", out_valid, 0);
            r[i] = ctl_rd_data;
            tick();
        end
        in_valid = 1'b0;
        s = sort4(r);
        for (int i = 0; i < 4; i++) begin
            ctl_wr_en   = 1'b1;
            ctl_wr_addr = t_addr'(i);
            ctl_wr_data = s[i];
            #1;
            chk("sort_wr_en", mem_wr_en, 1);
            chk("sort_wr_addr", mem_wr_addr, i);
            chk("sort_wr_data", mem_wr_data, s[i]);
            tick();
        end
        ctl_wr_en = 1'b0;
        sort_done = 1'b1;
        #1;
        chk("done_out_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        tick();
        sort_done = 1'b0;
    endtask

    // mode 0: always ready, 1: ready 1,0,0,1 then 1, 2: random ready; stalls also pulse sort_done.
    task automatic unload(input frame_t exp, input int mode);
        int k = 0;
        int cyc = 0;
        logic pat [4];
        logic rdy;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (k < 4 && cyc < 64) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc < 4) ? pat[cyc] : 1'b1;
            else rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            sort_done = (mode != 0) && !rdy;
            #1;
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, exp[k]);
            chk("out_last", out_last, (k == 3));
            chk("unload_rd_addr", mem_rd_addr, k);
            chk("unload_busy", busy, 0);
            chk("unload_wr_en", mem_wr_en, 0);
            if (rdy) k++;
            cyc++;
            tick();
        end
        chk("unload_count", k, 4);
        out_ready = 1'b0;
        sort_done = 1'b0;
        #1;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    frame_t f;
    logic [7:0] old;

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = '0; out_ready = 1'b1; sort_done = 1'b0;
        ctl_rd_addr = '0; ctl_wr_en = 1'b1; ctl_wr_addr = '0; ctl_wr_data = '0;
        @(negedge clk);
        tick();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sort_start", sort_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0; ctl_wr_en = 1'b0; out_ready = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);

        // directed frame, back-to-back load and full-rate unload
        f = '{8'd3, 8'd1, 8'd2, 8'd0};
        load_frame(f, 0, 1'b0);
        run_sorter();
        unload(sort4(f), 0);

        // gaps with stray sort_done / ctl writes, then stalled unload
        f = '{8'd200, 8'd17, 8'd99, 8'd17};
        load_frame(f, 2, 1'b1);
        run_sorter();
        unload(sort4(f), 1);

        // reset after two loaded words discards the partial frame
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'd9 - 8'(i);
            #1;
            chk("partial_wr_en", mem_wr_en, 1);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wr_en", mem_wr_en, 0);
        chk("midrst_busy", busy, 0);
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        f = '{8'd7, 8'd5, 8'd6, 8'd4};
        load_frame(f, 0, 1'b0);
        run_sorter();
        unload(sort4(f), 0);

        // reset landing in SORT must block a concurrent ctl write
        f = '{8'd11, 8'd33, 8'd22, 8'd44};
        load_frame(f, 0, 1'b0);
        old = mem[2];
        ctl_wr_en = 1'b1; ctl_wr_addr = t_addr'(2); ctl_wr_data = 8'h55; rst_n = 1'b0;
        #1;
        chk("sortrst_wr_en", mem_wr_en, 0);
        chk("sortrst_busy", busy, 0);
        tick();
        chk("sortrst_mem", mem[2], old);
        rst_n = 1'b1; ctl_wr_en = 1'b0;
        #1;
        chk("sortrst_in_ready", in_ready, 1);
        chk("sortrst_busy_after", busy, 0);

        // random frames streamed back-to-back
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) f[i] = 8'($urandom_range(0, 255));
            load_frame(f, (n % 2 == 0) ? 0 : 3, 1'(n % 3 == 1));
            run_sorter();
            unload(sort4(f), (n % 2 == 0) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
